// File: rtl/wishbone_ram_mux_n.sv
// Registered Wishbone decoder that fans one upstream port out to NUM_PORTS SRAM wrappers,
// with per-port cyc isolation, decode-miss/timeout errors and error status for the logic analyser.
module wishbone_ram_mux_n #(
  parameter int          NUM_PORTS  = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          INDEX_LSB  = 16,
  parameter int          INDEX_BITS = 4,
  parameter int          SPAN_BITS  = 12,
  parameter int          TIMEOUT    = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_ufp_stb_i,
  input  logic                      wbs_ufp_cyc_i,
  input  logic                      wbs_ufp_we_i,
  input  logic [3:0]                wbs_ufp_sel_i,
  input  logic [31:0]               wbs_ufp_adr_i,
  input  logic [31:0]               wbs_ufp_dat_i,
  output logic                      wbs_ufp_ack_o,
  output logic                      wbs_ufp_err_o,
  output logic [31:0]               wbs_ufp_dat_o,
  output logic [NUM_PORTS-1:0]      wbs_dfp_stb_o,
  output logic [NUM_PORTS-1:0]      wbs_dfp_cyc_o,
  output logic [NUM_PORTS-1:0]      wbs_dfp_we_o,
  output logic [4*NUM_PORTS-1:0]    wbs_dfp_sel_o,
  output logic [SPAN_BITS-1:0]      wbs_dfp_adr_o,
  output logic [32*NUM_PORTS-1:0]   wbs_dfp_dat_o,
  input  logic [32*NUM_PORTS-1:0]   wbs_dfp_dat_i,
  input  logic [NUM_PORTS-1:0]      wbs_dfp_ack_i,
  output logic [7:0]                err_count_o,
  output logic [31:0]               last_err_adr_o
);

  localparam int          UPPER_LSB    = INDEX_LSB + INDEX_BITS;
  localparam logic [31:0] GAP_MASK     = ((32'd1 << INDEX_LSB) - 32'd1) & ~((32'd1 << SPAN_BITS) - 32'd1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP_ACK, RESP_ERR} state_t;

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   portSel_q, portSel_d;
  logic                   we_q, we_d;
  logic [3:0]             sel_q, sel_d;
  logic [31:0]            wrData_q, wrData_d;
  logic [SPAN_BITS-1:0]   spanAdr_q, spanAdr_d;
  logic [31:0]            reqAdr_q, reqAdr_d;
  logic [15:0]            timer_q, timer_d;
  logic [31:0]            rdData_q, rdData_d;
  logic [7:0]             errCount_q, errCount_d;
  logic [31:0]            lastErrAdr_q, lastErrAdr_d;

  logic [INDEX_BITS-1:0]  reqIdx;
  logic                   upperOk, gapOk, idxOk, reqHit;
  logic                   selAck;
  logic [31:0]            selRdData;
  logic [7:0]             errCountInc;

  assign reqIdx  = wbs_ufp_adr_i[INDEX_LSB +: INDEX_BITS];
  assign upperOk = (wbs_ufp_adr_i >> UPPER_LSB) == (BASE_ADDR >> UPPER_LSB);
  assign gapOk   = (wbs_ufp_adr_i & GAP_MASK) == 32'd0;
  assign idxOk   = 32'(reqIdx) < 32'(NUM_PORTS);
  assign reqHit  = upperOk && gapOk && idxOk;

  // The one-hot port register doubles as the response mux select, so acks from idle ports never leak in.
  assign selAck      = |(wbs_dfp_ack_i & portSel_q);
  assign errCountInc = (errCount_q == 8'hFF) ? 8'hFF : errCount_q + 8'd1;

  always_comb begin
    selRdData = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (portSel_q[i]) selRdData = selRdData | wbs_dfp_dat_i[32*i +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    portSel_d    = portSel_q;
    we_d         = we_q;
    sel_d        = sel_q;
    wrData_d     = wrData_q;
    spanAdr_d    = spanAdr_q;
    reqAdr_d     = reqAdr_q;
    timer_d      = timer_q;
    rdData_d     = rdData_q;
    errCount_d   = errCount_q;
    lastErrAdr_d = lastErrAdr_q;
    case (state_q)
      IDLE: begin
        if (wbs_ufp_cyc_i && wbs_ufp_stb_i) begin
          we_d      = wbs_ufp_we_i;
          sel_d     = wbs_ufp_sel_i;
          wrData_d  = wbs_ufp_dat_i;
          spanAdr_d = wbs_ufp_adr_i[SPAN_BITS-1:0];
          reqAdr_d  = wbs_ufp_adr_i;
          if (reqHit) begin
            portSel_d = NUM_PORTS'(1) << reqIdx;
            timer_d   = 16'd0;
            state_d   = ACTIVE;
          end else begin
            errCount_d   = errCountInc;
            lastErrAdr_d = wbs_ufp_adr_i;
            state_d      = RESP_ERR;
          end
        end
      end
      // Abort outranks ack, which outranks the watchdog.
      ACTIVE: begin
        if (!wbs_ufp_cyc_i) begin
          portSel_d = '0;
          state_d   = IDLE;
        end else if (selAck) begin
          rdData_d  = selRdData;
          portSel_d = '0;
          state_d   = RESP_ACK;
        end else if (timer_q == TIMEOUT_LAST) begin
          portSel_d    = '0;
          errCount_d   = errCountInc;
          lastErrAdr_d = reqAdr_q;
          state_d      = RESP_ERR;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP_ACK: state_d = IDLE;
      RESP_ERR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      portSel_q    <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      wrData_q     <= '0;
      spanAdr_q    <= '0;
      reqAdr_q     <= '0;
      timer_q      <= '0;
      rdData_q     <= '0;
      errCount_q   <= '0;
      lastErrAdr_q <= '0;
    end else begin
      state_q      <= state_d;
      portSel_q    <= portSel_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      wrData_q     <= wrData_d;
      spanAdr_q    <= spanAdr_d;
      reqAdr_q     <= reqAdr_d;
      timer_q      <= timer_d;
      rdData_q     <= rdData_d;
      errCount_q   <= errCount_d;
      lastErrAdr_q <= lastErrAdr_d;
    end
  end

  assign wbs_ufp_ack_o  = (state_q == RESP_ACK);
  assign wbs_ufp_err_o  = (state_q == RESP_ERR);
  assign wbs_ufp_dat_o  = (state_q == RESP_ACK) ? rdData_q : 32'd0;
  assign wbs_dfp_stb_o  = portSel_q;
  assign wbs_dfp_cyc_o  = portSel_q;
  assign wbs_dfp_we_o   = portSel_q & {NUM_PORTS{we_q}};
  assign wbs_dfp_adr_o  = spanAdr_q;
  assign err_count_o    = errCount_q;
  assign last_err_adr_o = lastErrAdr_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_port
    assign wbs_dfp_sel_o[4*g +: 4]  = portSel_q[g] ? sel_q : 4'd0;
    assign wbs_dfp_dat_o[32*g +: 32] = portSel_q[g] ? wrData_q : 32'd0;
  end

endmodule

// File: tb/tb_wishbone_ram_mux_n.sv
// Randomised self-checking bench for wishbone_ram_mux_n: a transaction-level model predicts
// response kind and cycle, downstream routing and the error counters from the decode rules.
module tb_wishbone_ram_mux_n;

  localparam int NP  = 10;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ufpStb, ufpCyc, ufpWe;
  logic [3:0]        ufpSel;
  logic [31:0]       ufpAdr, ufpDatIn;
  logic              ufpAck, ufpErr;
  logic [31:0]       ufpDatOut;
  logic [NP-1:0]     dfpStb, dfpCyc, dfpWe;
  logic [4*NP-1:0]   dfpSel;
  logic [11:0]       dfpAdr;
  logic [32*NP-1:0]  dfpDatOut, dfpDatIn;
  logic [NP-1:0]     dfpAck;
  logic [7:0]        errCount;
  logic [31:0]       lastErrAdr;

  int                checkCount = 0;
  int                failCount  = 0;
  int                modelErrCount = 0;
  logic [31:0]       modelLastErr = '0;

  wishbone_ram_mux_n #(.NUM_PORTS(NP), .TIMEOUT(TMO)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wbs_ufp_stb_i  (ufpStb),
    .wbs_ufp_cyc_i  (ufpCyc),
    .wbs_ufp_we_i   (ufpWe),
    .wbs_ufp_sel_i  (ufpSel),
    .wbs_ufp_adr_i  (ufpAdr),
    .wbs_ufp_dat_i  (ufpDatIn),
    .wbs_ufp_ack_o  (ufpAck),
    .wbs_ufp_err_o  (ufpErr),
    .wbs_ufp_dat_o  (ufpDatOut),
    .wbs_dfp_stb_o  (dfpStb),
    .wbs_dfp_cyc_o  (dfpCyc),
    .wbs_dfp_we_o   (dfpWe),
    .wbs_dfp_sel_o  (dfpSel),
    .wbs_dfp_adr_o  (dfpAdr),
    .wbs_dfp_dat_o  (dfpDatOut),
    .wbs_dfp_dat_i  (dfpDatIn),
    .wbs_dfp_ack_i  (dfpAck),
    .err_count_o    (errCount),
    .last_err_adr_o (lastErrAdr)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [319:0] observed, input logic [319:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelHit(input logic [31:0] adr);
    return (adr[31:20] == 12'h300) && (adr[15:12] == 4'h0) && (int'(adr[19:16]) < NP);
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ack"}, 320'(ufpAck), 320'(0));
    checkOutput({tag, "_err"}, 320'(ufpErr), 320'(0));
    checkOutput({tag, "_dat"}, 320'(ufpDatOut), 320'(0));
    checkOutput({tag, "_stb"}, 320'(dfpStb), 320'(0));
    checkOutput({tag, "_cyc"}, 320'(dfpCyc), 320'(0));
  endtask

  task automatic checkErrStatus();
    checkOutput("err_count", 320'(errCount), 320'(modelErrCount));
    checkOutput("last_err_adr", 320'(lastErrAdr), 320'(modelLastErr));
  endtask

  // One full upstream transaction; ackDelay counts cycles from the downstream strobe to the slave's ack.
  task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                               input logic [31:0] wdat, input logic [31:0] rdat, input int ackDelay);
    bit               hit, isAck;
    int               port, respCycle;
    logic [NP-1:0]    oneHot, expStb;
    logic [4*NP-1:0]  expSel;
    logic [32*NP-1:0] expDat;
    hit    = modelHit(adr);
    port   = int'(adr[19:16]);
    oneHot = hit ? (NP'(1) << port) : '0;
    if (!hit) begin
      respCycle = 1; isAck = 0;
    end else if (ackDelay < TMO) begin
      respCycle = ackDelay + 2; isAck = 1;
    end else begin
      respCycle = TMO + 1; isAck = 0;
    end
    ufpCyc = 1'b1; ufpStb = 1'b1; ufpWe = we; ufpSel = sel; ufpAdr = adr; ufpDatIn = wdat;
    for (int c = 1; c <= respCycle; c++) begin
      tick();
      expStb = (c < respCycle) ? oneHot : '0;
      expSel = '0;
      expDat = '0;
      for (int p = 0; p < NP; p++) begin
        if (expStb[p]) begin
          expSel[4*p +: 4]  = sel;
          expDat[32*p +: 32] = wdat;
        end
      end
      checkOutput("dfp_stb", 320'(dfpStb), 320'(expStb));
      checkOutput("dfp_cyc", 320'(dfpCyc), 320'(expStb));
      checkOutput("dfp_we", 320'(dfpWe), 320'(expStb & {NP{we}}));
      checkOutput("dfp_sel", 320'(dfpSel), 320'(expSel));
      checkOutput("dfp_dat", 320'(dfpDatOut), 320'(expDat));
      if (expStb != '0) checkOutput("dfp_adr", 320'(dfpAdr), 320'(adr[11:0]));
      checkOutput("ufp_ack", 320'(ufpAck), 320'(c == respCycle && isAck));
      checkOutput("ufp_err", 320'(ufpErr), 320'(c == respCycle && !isAck));
      checkOutput("ufp_dat", 320'(ufpDatOut), 320'((c == respCycle && isAck) ? rdat : 32'd0));
      dfpAck = NP'($urandom) & ~oneHot;
      for (int p = 0; p < NP; p++) dfpDatIn[32*p +: 32] = $urandom;
      if (isAck && c == ackDelay + 1) begin
        dfpAck[port] = 1'b1;
        dfpDatIn[32*port +: 32] = rdat;
      end
      if (c == respCycle) begin
        ufpCyc = 1'b0; ufpStb = 1'b0; dfpAck = '0;
      end
    end
    tick();
    checkIdleOutputs("post");
    if (!isAck) begin
      if (modelErrCount < 255) modelErrCount++;
      modelLastErr = adr;
    end
    checkErrStatus();
  endtask

  // Upstream abandons the cycle at cycle abortAt while the selected slave acks in that same cycle.
  task automatic applyAbort(input logic [31:0] adr, input int abortAt);
    int            port;
    logic [NP-1:0] oneHot;
    port   = int'(adr[19:16]);
    oneHot = NP'(1) << port;
    ufpCyc = 1'b1; ufpStb = 1'b1; ufpWe = 1'b0; ufpSel = 4'hF; ufpAdr = adr; ufpDatIn = $urandom;
    for (int c = 1; c <= abortAt; c++) begin
      tick();
      checkOutput("abort_stb", 320'(dfpStb), 320'(oneHot));
      checkOutput("abort_early_ack", 320'(ufpAck), 320'(0));
      if (c == abortAt) begin
        ufpCyc = 1'b0; ufpStb = 1'b0;
        dfpAck = oneHot;
        dfpDatIn[32*port +: 32] = $urandom;
      end
    end
    tick();
    dfpAck = '0;
    checkIdleOutputs("abort");
    tick();
    checkIdleOutputs("abort_next");
    checkErrStatus();
  endtask

  task automatic applyResetMidActive(input logic [31:0] adr);
    ufpCyc = 1'b1; ufpStb = 1'b1; ufpWe = 1'b1; ufpSel = 4'h3; ufpAdr = adr; ufpDatIn = $urandom;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checkOutput("pre_reset_stb", 320'(dfpStb), 320'(NP'(1) << int'(adr[19:16])));
    end
    #2 rst = 1'b1;
    #1;
    modelErrCount = 0;
    modelLastErr  = '0;
    checkIdleOutputs("async_reset");
    checkErrStatus();
    ufpCyc = 1'b0; ufpStb = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checkIdleOutputs("after_reset");
  endtask

  initial begin
    logic [31:0] adr;
    int          kind;
    rst = 1'b1;
    ufpStb = 1'b0; ufpCyc = 1'b0; ufpWe = 1'b0; ufpSel = '0; ufpAdr = '0; ufpDatIn = '0;
    dfpAck = '0; dfpDatIn = '0;
    tick();
    tick();
    checkIdleOutputs("reset");
    checkOutput("reset_dfp_adr", 320'(dfpAdr), 320'(0));
    checkOutput("reset_dfp_dat", 320'(dfpDatOut), 320'(0));
    checkErrStatus();
    rst = 1'b0;
    tick();
    checkIdleOutputs("idle");

    applyStimulus(32'h3003_0010, 1'b1, 4'hF, 32'hA5A5_0001, 32'h1234_5678, 1);
    applyStimulus(32'h3009_0004, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 0);
    applyStimulus(32'h300A_0000, 1'b0, 4'hF, 32'h0, 32'h0, 0);
    applyStimulus(32'h3001_1000, 1'b1, 4'h1, 32'h5555_AAAA, 32'h0, 0);
    applyStimulus(32'h3005_0020, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1000);
    applyStimulus(32'h3000_0FFC, 1'b0, 4'hC, 32'h0, 32'h0BAD_CAFE, TMO - 1);
    applyAbort(32'h3002_0008, 1);
    applyStimulus(32'h3002_0008, 1'b0, 4'hF, 32'h0, 32'h7777_1111, 2);

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 9));
      adr  = 32'h3000_0000 | 32'($urandom_range(0, 4095));
      if (kind <= 5)      adr = adr | (32'($urandom_range(0, NP - 1)) << 16);
      else if (kind == 6) adr = adr | (32'($urandom_range(NP, 15)) << 16);
      else if (kind == 7) adr = adr | (32'($urandom_range(0, NP - 1)) << 16) | (32'($urandom_range(1, 15)) << 12);
      else if (kind == 8) begin
        adr = $urandom;
        if (adr[31:20] == 12'h300) adr[31] = ~adr[31];
      end else adr = adr | (32'($urandom_range(0, NP - 1)) << 16);
      if (kind == 9) applyAbort(adr, int'($urandom_range(1, TMO)));
      else applyStimulus(adr, 1'($urandom), 4'($urandom), $urandom, $urandom, int'($urandom_range(0, TMO + 3)));
    end

    applyResetMidActive(32'h3004_0100);
    applyStimulus(32'h3006_0040, 1'b1, 4'hF, 32'h0F0F_0F0F, 32'h1, 0);

    for (int n = 0; n < 260; n++) applyStimulus(32'h300F_0000 | 32'(n), 1'b0, 4'hF, 32'h0, 32'h0, 0);
    applyStimulus(32'h3008_0000, 1'b0, 4'hF, 32'h0, 32'h8888_0000, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/wishbone_ram_mux_n.md
Name: wishbone_ram_mux_n

Overview:
Registered, parametrised successor to the fixed 10-way SRAM Wishbone mux. It decodes one upstream Wishbone port onto NUM_PORTS downstream SRAM wrappers, using an index field of the address plus a per-port window check. Unlike the combinational generation, it has these additions:
- registers all downstream strobes and payload;
- isolates cyc per port;
- returns err on unmapped addresses;
- runs a watchdog timeout per transaction;
- exposes error status to the Caravel logic analyser.

It sits between the user-project Wishbone slave and the SRAM wrapper array.

Parameters:
NUM_PORTS, 10, number of downstream ports (1..16).
BASE_ADDR, 32'h3000_0000, region base; adr[31:INDEX_LSB+INDEX_BITS] must equal BASE_ADDR's same bits.
INDEX_LSB, 16, LSB of the port index field.
INDEX_BITS, 4, width of the port index field; index value i selects port i.
SPAN_BITS, 12, offset width inside a port window; adr[INDEX_LSB-1:SPAN_BITS] must be zero.
TIMEOUT, 255, cycles ACTIVE may wait for ack_i before err (1..65535).

Ports:
wb_clk_i  in  1  clock.
wb_rst_i  in  1  reset.
wbs_ufp_stb_i  in  1  upstream strobe.
wbs_ufp_cyc_i  in  1  upstream cycle.
wbs_ufp_we_i  in  1  upstream write enable.
wbs_ufp_sel_i  in  4  upstream byte selects.
wbs_ufp_adr_i  in  32  upstream address.
wbs_ufp_dat_i  in  32  upstream write data.
wbs_ufp_ack_o  out  1  upstream ack.
wbs_ufp_err_o  out  1  upstream error.
wbs_ufp_dat_o  out  32  upstream read data.
wbs_dfp_stb_o  out  NUM_PORTS  per-port strobe.
wbs_dfp_cyc_o  out  NUM_PORTS  per-port cycle.
wbs_dfp_we_o  out  NUM_PORTS  per-port write enable.
wbs_dfp_sel_o  out  4*NUM_PORTS  per-port byte selects; port i at [4i+3:4i].
wbs_dfp_adr_o  out  SPAN_BITS  broadcast window offset.
wbs_dfp_dat_o  out  32*NUM_PORTS  per-port write data.
wbs_dfp_dat_i  in  32*NUM_PORTS  per-port read data.
wbs_dfp_ack_i  in  NUM_PORTS  per-port ack.
err_count_o  out  8  saturating count of decode misses plus timeouts.
last_err_adr_o  out  32  upstream address of the most recent error.

Behaviour:
- Clock wb_clk_i, single domain. Reset wb_rst_i is asynchronous, active-high.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - timeout counter 0.
- Decode hit requires all of:
  - upper-bits match;
  - zero gap bits;
  - index < NUM_PORTS.
  Anything else is a miss.
- FSM IDLE:
  - On cyc_i & stb_i, latch we, sel, dat, adr[SPAN_BITS-1:0] and the port index.
  - Hit: set that port's stb/cyc/we/sel/dat on the next edge, then go to ACTIVE.
  - Miss: go to RESP_ERR; err_count++ (saturate at 255); last_err_adr <= adr_i.
- FSM ACTIVE:
  - Drive only the latched port. Every other port has stb, cyc, we, sel and dat all 0.
  - wbs_dfp_ack_i[idx] high: capture dat_i[idx] (captured on writes too; don't care), drop all downstream strobes, go to RESP_ACK.
  - ack_i from any non-selected port is ignored.
  - Counter reaches TIMEOUT without ack: drop downstream, go to RESP_ERR, err_count++, last_err_adr = latched full address.
  - Upstream cyc_i low (abort): drop downstream, return to IDLE, no ack/err; abort takes priority over an ack in the same cycle.
- FSM RESP_ACK / RESP_ERR:
  - ack_o (resp. err_o) is high for exactly one cycle, then go to IDLE.
  - dat_o holds the captured data during RESP_ACK and is 0 otherwise.
  - ack_o and err_o are never high together.
- Latency, hit with a same-cycle downstream ack: request seen in IDLE at cycle t, downstream stb at t+1, ack_o at t+2.
- Miss latency: err_o at t+1.
- Requests arriving outside IDLE are not accepted; upstream is held by the absence of ack.
- Reset mid-transaction clears everything immediately; a pending downstream stb drops asynchronously.
- The counter resets on every IDLE→ACTIVE transition.

Test Plan:
- Write 32'hA5A5_0001, sel 4'hF, to 32'h3003_0010; port 3 acks one cycle after stb. Expect: only dfp_stb_o[3] asserted, dfp_adr_o = 12'h010, dfp_dat_o[3] = A5A5_0001, ack_o exactly one cycle at t+3, err_count 0.
- Read 32'h3009_0004; port 9 returns 32'hCAFE_F00D with ack. Expect: dat_o = CAFE_F00D during the ack cycle and 0 the next cycle.
- Access 32'h300A_0000 (index 10 ≥ NUM_PORTS) and 32'h3001_1000 (nonzero gap bit). Expect: err_o one cycle each at t+1, no downstream stb, err_count = 2, last_err_adr = 3001_1000.
- Port 5 never acks, TIMEOUT = 8. Expect: stb_o[5] high for 8 cycles then dropped, err_o pulse, err_count incremented, last_err_adr = the accessed address.
- Upstream drops cyc during ACTIVE in the same cycle port 2 acks. Expect: no ack_o, no err_o, back in IDLE, a subsequent request is serviced normally.
- Assert wb_rst_i mid-ACTIVE. Expect: all dfp strobes 0 immediately, err_count 0, FSM in IDLE after release.
